// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller, IPIF user_logic slave with four 32-bit registers.
//   Latches rising edges of up to 16 synchronous source levels into ISR, arbitrates
//   among pending & enabled sources and drives a registered level irq to the CPU.
//   Register map (RdCE/WrCE bit -> offset):
//     [3] 0x00 ISR  R/W1C pending bits (a set beats a same-cycle clear)
//     [2] 0x04 IER  R/W   per-source enable
//     [1] 0x08 IVR  R: {valid, 27'd0, vec[3:0]}; any write = IAR (acknowledge)
//     [0] 0x0C MER  R/W   bit0 = master enable
// Ports:
//   Bus2IP_Clk, rst (async, active-high)
//   Bus2IP_Data/BE/RdCE/WrCE  bus request; writes need all byte enables set
//   IP2Bus_Data/RdAck/WrAck/Error  combinational bus response
//   src_irq  source levels (synchronous), irq  registered interrupt to the CPU
// Configuration macro: IRQ_CTRL_ROUND_ROBIN_EN selects a round-robin arbiter
//   (pointer advances past each acknowledged vector); default is fixed priority,
//   lowest index wins.
module irq_ctrl #(
  parameter int unsigned C_NUM_REG    = 4,
  parameter int unsigned C_SLV_DWIDTH = 32,
  parameter int unsigned C_NUM_SRC    = 4
) (
  input  logic                      Bus2IP_Clk,
  input  logic                      rst,
  input  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data,
  input  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_RdCE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_WrCE,
  output logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data,
  output logic                      IP2Bus_RdAck,
  output logic                      IP2Bus_WrAck,
  output logic                      IP2Bus_Error,
  input  logic [C_NUM_SRC-1:0]      src_irq,
  output logic                      irq
);

  localparam int unsigned VW     = 4;
  localparam int unsigned NW     = C_NUM_SRC;
  localparam int unsigned CE_ISR = 3;
  localparam int unsigned CE_IER = 2;
  localparam int unsigned CE_IVR = 1;
  localparam int unsigned CE_MER = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_GAP    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   src_q;
  logic [NW-1:0]   isr_q, isr_d;
  logic [NW-1:0]   ier_q, ier_d;
  logic            me_q, me_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic            irq_q, irq_d;

  logic [NW-1:0]   rise;
  logic [NW-1:0]   active;
  logic [NW-1:0]   vec_oh;
  logic [NW-1:0]   isr_clr;
  logic [NW-1:0]   isr_no_ack;
  logic [VW-1:0]   arb_vec;
  logic            wr_all;
  logic            isr_wr, ier_wr, iar_wr, mer_wr;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
  logic [VW-1:0]   ptr_q, ptr_d;
  logic [2*NW-1:0] rot_dbl;
  logic [NW-1:0]   rot;
  logic [VW-1:0]   off;
  logic [VW:0]     sum;
`endif

  // Upper write-data bits beyond the source count carry no state.
  logic unused_ok;
  assign unused_ok = ^{Bus2IP_Data[C_SLV_DWIDTH-1:NW]};

  assign rise   = src_irq & ~src_q;
  assign active = isr_q & ier_q;
  assign vec_oh = NW'(1) << vec_q;

  // Write decode; partial byte-enable writes are acked but have no effect.
  assign wr_all = &Bus2IP_BE;
  assign isr_wr = Bus2IP_WrCE[CE_ISR] & wr_all;
  assign ier_wr = Bus2IP_WrCE[CE_IER] & wr_all;
  assign iar_wr = Bus2IP_WrCE[CE_IVR] & wr_all;
  assign mer_wr = Bus2IP_WrCE[CE_MER] & wr_all;

  assign IP2Bus_RdAck = |Bus2IP_RdCE;
  assign IP2Bus_WrAck = |Bus2IP_WrCE;
  assign IP2Bus_Error = 1'b0;
  assign irq          = irq_q;

  // Read mux: exactly one RdCE selects a register, anything else returns 0.
  always_comb begin
    IP2Bus_Data = '0;
    if ($onehot(Bus2IP_RdCE)) begin
      if (Bus2IP_RdCE[CE_ISR])      IP2Bus_Data = C_SLV_DWIDTH'(isr_q);
      else if (Bus2IP_RdCE[CE_IER]) IP2Bus_Data = C_SLV_DWIDTH'(ier_q);
      else if (Bus2IP_RdCE[CE_IVR]) IP2Bus_Data = C_SLV_DWIDTH'({(state_q == S_ASSERT), 27'd0, vec_q});
      else                          IP2Bus_Data = C_SLV_DWIDTH'(me_q);
    end
  end

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
  // Rotate so bit 0 is the source at ptr, take the lowest set bit, un-rotate.
  always_comb begin
    rot_dbl = {active, active} >> ptr_q;
    rot     = rot_dbl[NW-1:0];
    off     = '0;
    for (int i = int'(C_NUM_SRC) - 1; i >= 0; i--) begin
      if (rot[i]) off = VW'(i);
    end
    sum     = (VW+1)'(ptr_q) + (VW+1)'(off);
    arb_vec = (sum >= (VW+1)'(NW)) ? VW'(sum - (VW+1)'(NW)) : VW'(sum);
  end
`else
  // Fixed priority: lowest active index wins.
  always_comb begin
    arb_vec = '0;
    for (int i = int'(C_NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) arb_vec = VW'(i);
    end
  end
`endif

  // Next-state: register writes, pending-bit update and the IDLE/ASSERT/GAP FSM.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    isr_clr = '0;
    ier_d   = ier_q;
    me_d    = me_q;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    if (ier_wr) ier_d = Bus2IP_Data[NW-1:0];
    if (mer_wr) me_d  = Bus2IP_Data[0];
    if (isr_wr) isr_clr = Bus2IP_Data[NW-1:0];
    isr_no_ack = (isr_q & ~isr_clr) | rise;

    case (state_q)
      S_IDLE: begin
        if (me_q && (|active)) begin
          vec_d   = arb_vec;
          state_d = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (iar_wr) begin
          isr_clr = isr_clr | vec_oh;
          state_d = S_GAP;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
          ptr_d   = (vec_q == VW'(NW - 1)) ? '0 : VW'(vec_q + VW'(1));
`endif
        end else if (!(|(isr_no_ack & vec_oh)) || !(|(ier_d & vec_oh)) || !me_d) begin
          // Serviced source withdrawn before the ack: drop irq without retiring.
          state_d = S_IDLE;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Rise is ORed last so a same-cycle set beats any clear.
    isr_d = (isr_q & ~isr_clr) | rise;
    irq_d = (state_d == S_ASSERT);
  end

  // State registers.
  always_ff @(posedge Bus2IP_Clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      isr_q   <= '0;
      ier_q   <= '0;
      me_q    <= 1'b0;
      vec_q   <= '0;
      irq_q   <= 1'b0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_irq;
      isr_q   <= isr_d;
      ier_q   <= ier_d;
      me_q    <= me_d;
      vec_q   <= vec_d;
      irq_q   <= irq_d;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl with a scoreboard queue.
module tb_irq_ctrl;

  localparam int unsigned NSRC = 4;
  localparam int REG_ISR = 0;
  localparam int REG_IER = 1;
  localparam int REG_IVR = 2;
  localparam int REG_MER = 3;

  logic            clk;
  logic            rst;
  logic [31:0]     wdata;
  logic [3:0]      be;
  logic [3:0]      rdce;
  logic [3:0]      wrce;
  logic [31:0]     rdata;
  logic            rdack;
  logic            wrack;
  logic            err;
  logic [NSRC-1:0] src;
  logic            irq;

  int checks;
  int errors;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  logic [31:0] first_vec;
  logic [31:0] second_vec;

  irq_ctrl #(
    .C_NUM_REG    (4),
    .C_SLV_DWIDTH (32),
    .C_NUM_SRC    (NSRC)
  ) dut (
    .Bus2IP_Clk   (clk),
    .rst          (rst),
    .Bus2IP_Data  (wdata),
    .Bus2IP_BE    (be),
    .Bus2IP_RdCE  (rdce),
    .Bus2IP_WrCE  (wrce),
    .IP2Bus_Data  (rdata),
    .IP2Bus_RdAck (rdack),
    .IP2Bus_WrAck (wrack),
    .IP2Bus_Error (err),
    .src_irq      (src),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic observe(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed 0x%08h expected none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed 0x%08h expected 0x%08h", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_irq(input string tag, input logic e);
    expect_val(tag, 32'(e));
    observe(32'(irq));
  endtask

  task automatic bus_read(input int r, input string tag, input logic [31:0] e);
    rdce = 4'(4'b1000 >> r);
    #1;
    expect_val(tag, e);
    observe(rdata);
    expect_val({tag, "_rdack"}, 32'd1);
    observe(32'(rdack));
    rdce = 4'b0000;
  endtask

  task automatic bus_write(input int r, input logic [31:0] d);
    wrce  = 4'(4'b1000 >> r);
    wdata = d;
    be    = 4'hF;
    step();
    wrce  = 4'b0000;
    wdata = 32'd0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    wdata  = 32'd0;
    be     = 4'hF;
    rdce   = 4'b0000;
    wrce   = 4'b0000;
    src    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_irq("irq_in_reset", 1'b0);
    rst = 1'b0;
    step();

    // Reset state and idle bus response.
    check_irq("irq_after_reset", 1'b0);
    bus_read(REG_ISR, "rst_isr", 32'd0);
    bus_read(REG_IER, "rst_ier", 32'd0);
    bus_read(REG_IVR, "rst_ivr", 32'd0);
    bus_read(REG_MER, "rst_mer", 32'd0);
    expect_val("idle_rdack", 32'd0);
    observe(32'(rdack));
    expect_val("idle_data", 32'd0);
    observe(rdata);
    expect_val("error_const", 32'd0);
    observe(32'(err));

    // Basic interrupt flow on source 2.
    bus_write(REG_MER, 32'h1);
    bus_write(REG_IER, 32'h5);
    bus_read(REG_MER, "mer_rd", 32'h1);
    bus_read(REG_IER, "ier_rd", 32'h5);
    rdce = 4'b1100;
    #1;
    expect_val("multi_rdce_data", 32'd0);
    observe(rdata);
    rdce = 4'b0000;
    src[2] = 1'b1;
    step();
    bus_read(REG_ISR, "t2_isr_set", 32'h4);
    check_irq("t2_irq_k", 1'b0);
    src[2] = 1'b0;
    step();
    check_irq("t2_irq_k1", 1'b1);
    bus_read(REG_IVR, "t2_ivr", 32'h8000_0002);
    bus_write(REG_IVR, 32'hDEAD_BEEF);
    check_irq("t2_irq_ack", 1'b0);
    bus_read(REG_ISR, "t2_isr_cleared", 32'h0);
    step();
    check_irq("t2_irq_gap", 1'b0);
    bus_read(REG_IVR, "t2_ivr_idle", 32'h0000_0002);
    step();
    check_irq("t2_irq_quiet", 1'b0);

    // Two simultaneous sources: arbitration order.
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    first_vec  = 32'd3;
    second_vec = 32'd1;
`else
    first_vec  = 32'd1;
    second_vec = 32'd3;
`endif
    bus_write(REG_IER, 32'hF);
    src = 4'b1010;
    step();
    bus_read(REG_ISR, "t3_isr", 32'hA);
    check_irq("t3_irq_k", 1'b0);
    src = 4'b0000;
    step();
    check_irq("t3_irq_first", 1'b1);
    bus_read(REG_IVR, "t3_ivr_first", 32'h8000_0000 | first_vec);
    bus_write(REG_IVR, 32'h0);
    check_irq("t3_irq_ack1", 1'b0);
    bus_read(REG_ISR, "t3_isr_after1", 32'hA & ~(32'd1 << first_vec));
    step();
    check_irq("t3_irq_gap", 1'b0);
    step();
    check_irq("t3_irq_second", 1'b1);
    bus_read(REG_IVR, "t3_ivr_second", 32'h8000_0000 | second_vec);
    bus_write(REG_IVR, 32'h0);
    check_irq("t3_irq_ack2", 1'b0);
    bus_read(REG_ISR, "t3_isr_after2", 32'h0);
    step();

    // Abort: W1C of the serviced bit while in ASSERT; source held high.
    src = 4'b0001;
    step();
    bus_read(REG_ISR, "t4_isr", 32'h1);
    step();
    check_irq("t4_irq_on", 1'b1);
    bus_read(REG_IVR, "t4_ivr", 32'h8000_0000);
    bus_write(REG_ISR, 32'h1);
    check_irq("t4_irq_abort", 1'b0);
    bus_read(REG_ISR, "t4_isr_w1c", 32'h0);
    step();
    check_irq("t4_irq_stay1", 1'b0);
    step();
    check_irq("t4_irq_stay2", 1'b0);
    bus_read(REG_ISR, "t4_isr_held", 32'h0);
    bus_read(REG_IVR, "t4_ivr_invalid", 32'h0);
    src = 4'b0000;

    // Partial byte-enable write ignored; master enable gating.
    bus_write(REG_IER, 32'h1);
    wrce  = 4'b0100;
    wdata = 32'hF;
    be    = 4'b0011;
    #1;
    expect_val("t5_wrack_partial", 32'd1);
    observe(32'(wrack));
    step();
    wrce  = 4'b0000;
    be    = 4'hF;
    wdata = 32'd0;
    bus_read(REG_IER, "t5_ier_unchanged", 32'h1);
    bus_write(REG_MER, 32'h0);
    src = 4'b0001;
    step();
    bus_read(REG_ISR, "t5_isr_me0", 32'h1);
    check_irq("t5_irq_me0_k", 1'b0);
    src = 4'b0000;
    step();
    check_irq("t5_irq_me0_k1", 1'b0);
    step();
    check_irq("t5_irq_me0_k2", 1'b0);
    bus_write(REG_MER, 32'h1);
    check_irq("t5_irq_me_w", 1'b0);
    step();
    check_irq("t5_irq_me_w1", 1'b1);
    bus_read(REG_IVR, "t5_ivr", 32'h8000_0000);
    bus_write(REG_IVR, 32'h0);
    check_irq("t5_irq_ack", 1'b0);
    bus_read(REG_ISR, "t5_isr_ack", 32'h0);
    step();

    // Ack coinciding with a fresh rise on the serviced source.
    bus_write(REG_IER, 32'h2);
    src = 4'b0010;
    step();
    src = 4'b0000;
    step();
    check_irq("t6_irq_on", 1'b1);
    bus_read(REG_IVR, "t6_ivr", 32'h8000_0001);
    src = 4'b0010;
    bus_write(REG_IVR, 32'h0);
    check_irq("t6_irq_ack", 1'b0);
    bus_read(REG_ISR, "t6_isr_kept", 32'h2);
    step();
    check_irq("t6_irq_gap", 1'b0);
    step();
    check_irq("t6_irq_reassert", 1'b1);
    bus_read(REG_IVR, "t6_ivr_again", 32'h8000_0001);

    // Asynchronous reset while irq is high.
    rst = 1'b1;
    #1;
    check_irq("t7_irq_async_rst", 1'b0);
    bus_read(REG_ISR, "t7_isr_rst", 32'h0);
    bus_read(REG_IER, "t7_ier_rst", 32'h0);
    src = 4'b0000;
    step();
    rst = 1'b0;
    step();
    check_irq("t7_irq_after", 1'b0);
    bus_read(REG_MER, "t7_mer_rst", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
